mmio_store_port: RTL

//  Memory-mapped output port on the data bus of the multi-cycle RISC-V core
//  (DataAdr/WriteData/MemWrite).
//  - Stores to TX_ADDR are captured into a FIFO and drained on a valid/ready stream.
//  - A status word at STAT_ADDR is readable by loads and writable by stores.
//  - The core never stalls. A store that arrives when the FIFO is full is dropped
//    and flagged as overflow.

---
 rtl/mmio_pkg.sv | 17 +
 rtl/mmio_store_port_sync_fifo.sv | 56 +++++
 rtl/mmio_store_port.sv | 76 +++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped store port: default addresses and
// the bit layout of the status (read) and control (write) words.
package mmio_pkg;

    localparam logic [31:0] TX_ADDR_DEF   = 32'h0000_0064;
    localparam logic [31:0] STAT_ADDR_DEF = 32'h0000_0068;

    localparam int STAT_OVF     = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_FULL    = 2;
    localparam int STAT_CNT_LSB = 8;
    localparam int STAT_CNT_W   = 8;

    localparam int CTRL_CLR_OVF = 0;
    localparam int CTRL_FLUSH   = 1;

endpackage

// File: rtl/mmio_store_port_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers, flush, and a drop indication for
// pushes refused because the FIFO is full and nothing is leaving.
module sync_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o,
    output logic          empty_o,
    output logic          full_o,
    output logic          drop_o,
    output logic [AW:0]   count_o
);

    logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count_o = wptr_q - rptr_q;

    // A flush owns the read pointer, so a coincident pop is discarded.
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && (!full_o || do_pop);
    assign drop_o  = push_i && !do_push;

    // Storage is only read behind the empty gate, so it needs no reset.
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q + (AW+1)'(do_push);
        rptr_d = flush_i ? wptr_q : rptr_q + (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/mmio_store_port.sv
// Memory-mapped output port: TX stores feed a FIFO drained over valid/ready;
// a status/control word reports and clears overflow and can flush the FIFO.
module mmio_store_port
    import mmio_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] TX_ADDR   = TX_ADDR_DEF,
    parameter logic [31:0] STAT_ADDR = STAT_ADDR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write,
    input  logic [31:0] data_adr,
    input  logic [31:0] write_data,
    output logic        rd_hit,
    output logic [31:0] rd_data,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready,
    output logic        overflow
);

    localparam int CW = $clog2(DEPTH) + 1;

    if (TX_ADDR == STAT_ADDR) begin : g_addr_clash
        $error("mmio_store_port: TX_ADDR and STAT_ADDR must differ");
    end

    logic          push, stat_wr, flush, clr_ovf;
    logic          empty, full, drop;
    logic [CW-1:0] count;
    logic          ovf_q, ovf_d;

    assign push    = mem_write && (data_adr == TX_ADDR);
    assign stat_wr = mem_write && (data_adr == STAT_ADDR);
    assign flush   = stat_wr && write_data[CTRL_FLUSH];
    assign clr_ovf = stat_wr && write_data[CTRL_CLR_OVF];

    sync_fifo #(.DW(32), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push),
        .pop_i   (out_ready),
        .flush_i (flush),
        .wdata_i (write_data),
        .rdata_o (out_data),
        .empty_o (empty),
        .full_o  (full),
        .drop_o  (drop),
        .count_o (count)
    );

    assign out_valid = !empty;
    assign overflow  = ovf_q;
    assign rd_hit    = (data_adr == STAT_ADDR);

    always_comb begin
        ovf_d = ovf_q;
        if (drop)    ovf_d = 1'b1;
        if (clr_ovf) ovf_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    always_comb begin
        rd_data                                 = '0;
        rd_data[STAT_OVF]                       = ovf_q;
        rd_data[STAT_EMPTY]                     = empty;
        rd_data[STAT_FULL]                      = full;
        rd_data[STAT_CNT_LSB +: STAT_CNT_W]     = STAT_CNT_W'(count);
    end

endmodule
